// File: rtl/online_r4_pkg.sv
// Shared sizing, digit type and FSM encoding for the radix-4 online arithmetic blocks.
package online_r4_pkg;

    localparam int N = 7;
    localparam int C = 3;
    localparam int W = 2 * N + 1;

    typedef logic signed [C-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/otf_step_r4.sv
// One on-the-fly conversion step: next Q and QM (= Q-1) after appending one radix-4 digit.
module otf_step_r4 #(
    parameter int W = 15,
    parameter int C = 3
) (
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] qm_i,
    input  logic [C-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] qm_o
);

    logic [W-1:0] d_ext;
    logic [W-1:0] q4;
    logic [W-1:0] qm4;
    logic         d_neg;
    logic         d_pos;

    assign d_ext = {{(W-C){d_i[C-1]}}, d_i};
    assign q4    = {q_i[W-3:0], 2'b00};
    assign qm4   = {qm_i[W-3:0], 2'b00};
    assign d_neg = d_i[C-1];
    assign d_pos = !d_neg && (|d_i);

    // A negative digit borrows from the lower string QM, so no carry ever ripples.
    always_comb begin
        q_o  = d_neg ? (qm4 + W'(4) + d_ext) : (q4 + d_ext);
        qm_o = d_pos ? (q4 + d_ext - W'(1)) : (qm4 + W'(3) + d_ext);
    end

endmodule

// File: rtl/otf_convert_r4.sv
// Converts an MSD-first signed radix-4 digit stream into a two's-complement integer.
module otf_convert_r4 #(
    parameter int N = online_r4_pkg::N,
    parameter int C = online_r4_pkg::C
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         start,
    input  logic         di_valid,
    input  logic [C-1:0] di,
    output logic [2*N:0] q,
    output logic         q_valid,
    output logic         busy,
    output logic         err
);

    import online_r4_pkg::*;

    localparam int W  = 2 * N + 1;
    localparam int CW = $clog2(N + 1);

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   accm_q;
    logic [W-1:0]   acc_d;
    logic [W-1:0]   accm_d;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   q_q;
    logic           err_q;
    logic           accept;
    logic           last_digit;
    logic           illegal_digit;

    assign accept        = (state_q == RUN) && di_valid && !start;
    assign last_digit    = (cnt_q == CW'(N - 1));
    assign illegal_digit = (di == {1'b1, {(C-1){1'b0}}});

    otf_step_r4 #(
        .W (W),
        .C (C)
    ) u_step (
        .q_i  (acc_q),
        .qm_i (accm_q),
        .d_i  (di),
        .q_o  (acc_d),
        .qm_o (accm_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (start) begin
                    state_d = RUN;
                end else if (accept && last_digit) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == RUN);
        q_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            accm_q <= '1;
            cnt_q  <= '0;
            q_q    <= '0;
            err_q  <= 1'b0;
        end else if (en) begin
            if (start) begin
                acc_q  <= '0;
                accm_q <= '1;
                cnt_q  <= '0;
                q_q    <= '0;
                err_q  <= 1'b0;
            end else if (accept) begin
                acc_q  <= acc_d;
                accm_q <= accm_d;
                cnt_q  <= cnt_q + CW'(1);
                // -4 is outside the redundant digit set but still converts exactly.
                if (illegal_digit) begin
                    err_q <= 1'b1;
                end
                if (last_digit) begin
                    q_q <= acc_d;
                end
            end
        end
    end

    assign q   = q_q;
    assign err = err_q;

endmodule

// File: tb/tb_otf_convert_r4.sv
// Directed bench for otf_convert_r4: reset, conversions, gaps, enable stalls, restart and error flag.
`timescale 1ns/1ps
module tb_otf_convert_r4;

    logic        clk;
    logic        reset;
    logic        en;
    logic        start;
    logic        di_valid;
    logic [2:0]  di;
    logic [14:0] q;
    logic        q_valid;
    logic        busy;
    logic        err;

    int checks;
    int errors;

    otf_convert_r4 #(
        .N (7),
        .C (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .start    (start),
        .di_valid (di_valid),
        .di       (di),
        .q        (q),
        .q_valid  (q_valid),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        en       = 1'b1;
        start    = 1'b1;
        di_valid = 1'b0;
        step();
        start = 1'b0;
    endtask

    // Feeds seven digits back-to-back (dv packs digit 0 in the top bits) and checks the result.
    task automatic run_digits(input string name, input logic [20:0] dv,
                              input int exp_q, input logic exp_err);
        logic [14:0] exp_w;
        logic [2:0]  d;
        exp_w = exp_q[14:0];
        do_start();
        for (int i = 0; i < 7; i++) begin
            d        = dv[20-3*i -: 3];
            di_valid = 1'b1;
            di       = d;
            step();
            checks++;
            if (q_valid !== (i == 6)) begin
                errors++;
                $display("FAIL %s q_valid digit %0d: got %b need %b", name, i, q_valid, (i == 6));
            end
        end
        di_valid = 1'b0;
        checks++;
        if (q !== exp_w) begin
            errors++;
            $display("FAIL %s q: got %0d need %0d", name, $signed(q), exp_q);
        end
        checks++;
        if (err !== exp_err || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s err/busy: got %b/%b need %b/0", name, err, busy, exp_err);
        end
        step();
        checks++;
        if (q_valid !== 1'b0 || q !== exp_w) begin
            errors++;
            $display("FAIL %s after_done: q_valid %b q %0d need 0 %0d", name, q_valid, $signed(q), exp_q);
        end
        $display("txn %s digits=%h q=%0d err=%b", name, dv, $signed(q), err);
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; start = 1'b0; di_valid = 1'b0; di = 3'd0;
        step(); step();
        reset = 1'b0;
        checks++;
        if (q !== 15'd0 || q_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: q %0d qv %b busy %b err %b need all 0", q, q_valid, busy, err);
        end
        en = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy %b qv %b need 0 0", busy, q_valid);
        end
        $display("txn reset q=%0d busy=%b", q, busy);
    endtask

    task automatic test_conversions();
        run_digits("one_msd",  {3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 4096, 1'b0);
        run_digits("mixed",    {3'd1, 3'b111, 3'd0, 3'd0, 3'd0, 3'd0, 3'b111}, 3071, 1'b0);
        run_digits("minus1",   {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b111}, -1, 1'b0);
        run_digits("all3",     {7{3'd3}}, 16383, 1'b0);
        run_digits("allm3",    {7{3'b101}}, -16383, 1'b0);
    endtask

    task automatic test_idle_ignore();
        di_valid = 1'b1; di = 3'd3;
        step(); step(); step();
        di_valid = 1'b0;
        checks++;
        if (q !== 15'h4001 || busy !== 1'b0 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: q %0d busy %b qv %b need -16383 0 0", $signed(q), busy, q_valid);
        end
        $display("txn idle_ignore q=%0d", $signed(q));
    endtask

    task automatic test_gaps();
        do_start();
        di_valid = 1'b1; di = 3'd2; step();
        di_valid = 1'b0; step();
        en = 1'b0; di_valid = 1'b1; di = 3'd1; step();
        en = 1'b1; di = 3'd3; step();
        di_valid = 1'b0; step();
        checks++;
        if (busy !== 1'b1 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL gaps_mid: busy %b qv %b need 1 0", busy, q_valid);
        end
        for (int i = 0; i < 5; i++) begin
            di_valid = 1'b1; di = 3'd0; step();
            checks++;
            if (q_valid !== (i == 4)) begin
                errors++;
                $display("FAIL gaps q_valid zero %0d: got %b need %b", i, q_valid, (i == 4));
            end
            if (i == 2) begin
                di_valid = 1'b0; step();
            end
        end
        en = 1'b0; di_valid = 1'b0;
        step(); step();
        checks++;
        if (q_valid !== 1'b1 || q !== 15'd11264) begin
            errors++;
            $display("FAIL gaps_hold: qv %b q %0d need 1 11264", q_valid, $signed(q));
        end
        en = 1'b1; step();
        checks++;
        if (q_valid !== 1'b0 || busy !== 1'b0 || q !== 15'd11264) begin
            errors++;
            $display("FAIL gaps_end: qv %b busy %b q %0d need 0 0 11264", q_valid, busy, $signed(q));
        end
        $display("txn gaps q=%0d", $signed(q));
    endtask

    task automatic test_reset_mid();
        int seen_qv;
        do_start();
        for (int i = 0; i < 3; i++) begin
            di_valid = 1'b1; di = 3'd1; step();
        end
        reset = 1'b1; di_valid = 1'b0; step();
        reset = 1'b0;
        checks++;
        if (q !== 15'd0 || q_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: q %0d qv %b busy %b err %b need all 0", $signed(q), q_valid, busy, err);
        end
        seen_qv = 0;
        for (int i = 0; i < 6; i++) begin
            di_valid = 1'b1; di = 3'd0; step();
            if (q_valid === 1'b1 || busy === 1'b1) seen_qv++;
        end
        di_valid = 1'b0;
        checks++;
        if (seen_qv != 0) begin
            errors++;
            $display("FAIL reset_mid_abandon: %0d cycles with qv/busy need 0", seen_qv);
        end
        $display("txn reset_mid q=%0d", $signed(q));
        run_digits("after_reset", {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2}, 2, 1'b0);
    endtask

    task automatic test_restart();
        do_start();
        for (int i = 0; i < 3; i++) begin
            di_valid = 1'b1; di = 3'd3; step();
        end
        di_valid = 1'b0;
        $display("txn restart mid-run busy=%b", busy);
        run_digits("restart", {3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 4096, 1'b0);
    endtask

    task automatic test_neg4();
        run_digits("neg4", {3'b100, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, -16384, 1'b1);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL neg4_sticky: err %b need 1", err);
        end
        do_start();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL neg4_clear: err %b busy %b need 0 1", err, busy);
        end
        $display("txn neg4_clear err=%b", err);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_conversions();
        test_idle_ignore();
        test_gaps();
        test_reset_mid();
        test_restart();
        test_neg4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/otf_convert_r4.md
OTF_CONVERT_R4 -- requirements
Module: otf_convert_r4

Interface
REQ-001 SHALL have parameter N, default 7, meaning result digits per operand (online_sub_r4 output length n+1).
REQ-002 SHALL have parameter C, default 3, meaning bits per signed radix-4 digit.
REQ-003 SHALL have derived width W = 2*N+1, meaning bits of the two's-complement result.
REQ-004 SHALL have port clk, input, 1, meaning single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, meaning clock enable; when low all state holds.
REQ-007 SHALL have port start, input, 1, meaning a one-cycle pulse that clears the accumulators and begins a conversion.
REQ-008 SHALL have port di_valid, input, 1, meaning di carries a digit this cycle.
REQ-009 SHALL have port di, input, C, meaning signed digit, MSD first (online_sub_r4 zi).
REQ-010 SHALL have port q, output, W, meaning signed integer value of the digit string.
REQ-011 SHALL have port q_valid, output, 1, meaning a one-cycle pulse when q is final.
REQ-012 SHALL have port busy, output, 1, meaning conversion in progress.
REQ-013 SHALL have port err, output, 1, meaning sticky flag: illegal digit -4 received.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL, in any state with en=1 and start=1, clear Q to 0, QM to all-ones (-1), digit count to 0 and err to 0, then enter RUN.
REQ-016 SHALL ignore di_valid in the start cycle; the first accepted digit arrives in a later cycle.
REQ-017 SHALL, in RUN with en=1 and di_valid=1, accept di and apply Q' = 4Q+d if d>=0, else 4QM+(4+d).
REQ-018 SHALL apply QM' = 4Q+(d-1) if d>0, else 4QM+(3+d), in the same cycle; all arithmetic is W-bit two's complement.
REQ-019 SHALL, on acceptance of digit N, enter DONE, drive q from the updated Q and pulse q_valid high for exactly that DONE cycle.
REQ-020 SHALL go from DONE to IDLE on the next enabled cycle.
REQ-021 SHALL hold q and err in IDLE until the next start.
REQ-022 SHALL keep RUN and not advance the count when di_valid=0 (gaps allowed).
REQ-023 SHALL ignore di_valid in IDLE and DONE.
REQ-024 SHALL assert busy exactly while in RUN.
REQ-025 SHALL set err on digit 3'b100 (-4) while still converting arithmetically with d=-4 (result stays exact).
REQ-026 SHALL freeze state, counters, q, q_valid and busy when en=0; a pending q_valid pulse extends until the next enabled cycle.
REQ-027 SHALL give start priority over digit acceptance and restart a conversion when start arrives mid-RUN.

Reset
REQ-028 SHALL, with reset=1 at a clock edge, set state=IDLE, Q=0, QM=-1, count=0, q=0, q_valid=0, busy=0 and err=0, regardless of en.
REQ-029 SHALL let reset during RUN abandon the conversion with no q_valid pulse.

Structure
REQ-030 SHALL place N, C, W, the signed digit type and the FSM state enum in shared package online_r4_pkg.
REQ-031 SHALL implement the Q/QM next-value selection (REQ-017/018) in combinational sub-module otf_step_r4.
REQ-032 SHALL size the count register to ceil(log2(N+1)) bits.

Verification
REQ-033 SHALL cover: start, then digits 1,0,0,0,0,0,0 back-to-back -> q=4096, q_valid one cycle, err=0.
REQ-034 SHALL cover: digits 1,-1,0,0,0,0,-1 -> q=3071; digits 0,0,0,0,0,0,-1 -> q=-1.
REQ-035 SHALL cover: all digits 3 -> q=16383; all digits -3 -> q=-16383.
REQ-036 SHALL cover: digits 2,3 with di_valid gaps and en=0 cycles interleaved -> same q as the gap-free run (2,3,0,0,0,0,0 -> 11264); q_valid pulse only after the 7th accepted digit.
REQ-037 SHALL cover: reset asserted after 3 digits -> all outputs 0 next cycle, no q_valid; new start then 0,0,0,0,0,0,2 -> q=2.
REQ-038 SHALL cover: digit -4 then 0,0,0,0,0,0 -> err=1, q=-16384; the next start clears err.
